// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and key decoding for the keypad time-entry path.
package keypad_pkg;

  localparam int unsigned NUM_KEYS = 12;
  localparam int unsigned KEY_STAR = 10;
  localparam int unsigned KEY_HASH = 11;

  localparam logic [3:0] DEFAULT_ENTRY_MODE = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EDIT  = 2'd1,
    ST_CHECK = 2'd2
  } entry_state_t;

  // Index of the highest set key bit; only meaningful for one-hot input.
  function automatic logic [3:0] key_index(input logic [NUM_KEYS-1:0] keys);
    logic [3:0] idx;
    idx = 4'd0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (keys[k]) idx = 4'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounces the 12-key one-hot keypad into single key events, one per press.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keypad_in,
  output logic                key_evt,
  output logic [3:0]          key_code
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);

  logic [NUM_KEYS-1:0] cand;
  logic [CNT_W-1:0]    cnt;
  logic                locked;
  logic                same;
  logic                stable_now;
  logic                one_hot;

  // The current cycle completes a stable run when the count already holds DEBOUNCE_CYCLES-1.
  always_comb begin
    same       = (keypad_in == cand);
    stable_now = same && (cnt == CNT_LAST);
    one_hot    = ($countones(keypad_in) == 1);
    key_evt    = stable_now && one_hot && !locked;
    key_code   = key_index(keypad_in);
  end

  // Track the run length of the current pattern and lock out presses until a stable release.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand   <= '0;
      cnt    <= '0;
      locked <= 1'b0;
    end else begin
      cand <= keypad_in;
      if (!same) begin
        cnt <= CNT_W'(1);
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (key_evt) begin
        locked <= 1'b1;
      end else if (stable_now && (keypad_in == '0)) begin
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad BCD value entry: edit buffer, cursor, backspace/cancel, range-checked commit and timeout.
module keypad_time_entry
  import keypad_pkg::*;
#(
  parameter int unsigned           NUM_DIGITS      = 6,
  parameter logic [4*NUM_DIGITS-1:0] FIELD_MAX     = 24'h235959,
  parameter logic [4*NUM_DIGITS-1:0] RESET_VALUE   = '0,
  parameter logic [3:0]            ENTRY_MODE      = DEFAULT_ENTRY_MODE,
  parameter int unsigned           DEBOUNCE_CYCLES = 20000,
  parameter int unsigned           TIMEOUT_CYCLES  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    enable,
  input  logic [NUM_KEYS-1:0]           keypad_in,
  output logic [4*NUM_DIGITS-1:0]       value,
  output logic                          value_valid,
  output logic [4*NUM_DIGITS-1:0]       edit_buf,
  output logic [$clog2(NUM_DIGITS+1)-1:0] cursor,
  output logic                          busy,
  output logic                          error
);

  localparam int unsigned VAL_W      = 4 * NUM_DIGITS;
  localparam int unsigned CUR_W      = $clog2(NUM_DIGITS + 1);
  localparam int unsigned NUM_FIELDS = NUM_DIGITS / 2;
  localparam int unsigned TO_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  entry_state_t     state;
  logic [TO_W-1:0]  to_cnt;
  logic             key_evt;
  logic [3:0]       key_code;
  logic             in_mode;
  logic             is_digit;
  logic [VAL_W-1:0] wr_buf;
  logic [VAL_W-1:0] bs_buf;
  logic             fields_ok;

  keypad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .keypad_in(keypad_in),
    .key_evt  (key_evt),
    .key_code (key_code)
  );

  // Candidate buffers for a digit write at the cursor and a backspace behind it.
  always_comb begin
    in_mode  = (enable == ENTRY_MODE);
    is_digit = (key_code < 4'd10);
    wr_buf   = edit_buf;
    bs_buf   = edit_buf;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cursor == CUR_W'(i))     wr_buf[4*(NUM_DIGITS-1-i) +: 4] = key_code;
      if (cursor == CUR_W'(i + 1)) bs_buf[4*(NUM_DIGITS-1-i) +: 4] = 4'd0;
    end
  end

  // Every digit pair must be within its limit; BCD pairs order correctly as unsigned bytes.
  always_comb begin
    fields_ok = 1'b1;
    for (int p = 0; p < NUM_FIELDS; p++) begin
      if (edit_buf[8*p +: 8] > FIELD_MAX[8*p +: 8]) fields_ok = 1'b0;
    end
  end

  // Entry FSM with registered outputs; leaving the mode takes priority over keys and CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      value       <= RESET_VALUE;
      edit_buf    <= RESET_VALUE;
      cursor      <= '0;
      value_valid <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
      to_cnt      <= '0;
    end else begin
      value_valid <= 1'b0;
      error       <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (in_mode) begin
            state    <= ST_EDIT;
            busy     <= 1'b1;
            edit_buf <= value;
            cursor   <= '0;
            to_cnt   <= '0;
          end
        end
        ST_EDIT: begin
          if (!in_mode) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            edit_buf <= value;
            cursor   <= '0;
          end else if (key_evt) begin
            to_cnt <= '0;
            if (is_digit) begin
              if (cursor != CUR_W'(NUM_DIGITS)) begin
                edit_buf <= wr_buf;
                cursor   <= cursor + CUR_W'(1);
              end
            end else if (key_code == 4'(KEY_STAR)) begin
              if (cursor != '0) begin
                edit_buf <= bs_buf;
                cursor   <= cursor - CUR_W'(1);
              end else begin
                edit_buf <= value;
              end
            end else begin
              state <= ST_CHECK;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            if (to_cnt == TO_W'(TO_LAST)) begin
              edit_buf <= value;
              cursor   <= '0;
              to_cnt   <= '0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end
        ST_CHECK: begin
          to_cnt <= '0;
          cursor <= '0;
          if (!in_mode) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            edit_buf <= value;
          end else begin
            state <= ST_EDIT;
            if (fields_ok) begin
              value       <= edit_buf;
              value_valid <= 1'b1;
            end else begin
              error    <= 1'b1;
              edit_buf <= value;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_time_entry.sv
// Self-checking bench for keypad_time_entry against a digit-array reference model.
module tb_keypad_time_entry;

  localparam int unsigned ND   = 6;
  localparam int unsigned VW   = 4 * ND;
  localparam int unsigned DB   = 4;
  localparam int unsigned TO   = 50;
  localparam int unsigned HOLD = DB + 4;
  localparam int unsigned REL  = DB + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    enable;
  logic [11:0]   keypad_in;
  logic [VW-1:0] value;
  logic          value_valid;
  logic [VW-1:0] edit_buf;
  logic [2:0]    cursor;
  logic          busy;
  logic          error;

  keypad_time_entry #(
    .NUM_DIGITS     (ND),
    .FIELD_MAX      (24'h235959),
    .RESET_VALUE    (24'h000000),
    .ENTRY_MODE     (4'b0100),
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .keypad_in  (keypad_in),
    .value      (value),
    .value_valid(value_valid),
    .edit_buf   (edit_buf),
    .cursor     (cursor),
    .busy       (busy),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: decimal digits, MSD first.
  int m_value[ND];
  int m_buf[ND];
  int m_cursor;
  bit m_active;
  int m_vv;
  int m_err;
  int lim[ND/2] = '{23, 59, 59};

  // Observations from the last press.
  int vv_cnt, err_cnt, vv_at, err_at;
  logic [VW-1:0] snap_value, snap_buf;
  logic [2:0]    snap_cursor;
  logic          snap_vv, snap_err, snap_busy;

  function automatic logic [VW-1:0] exp_value();
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) r[4*(ND-1-i) +: 4] = 4'(m_value[i]);
    return r;
  endfunction

  function automatic logic [VW-1:0] exp_buf();
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) r[4*(ND-1-i) +: 4] = 4'(m_buf[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_value[i] = 0;
      m_buf[i]   = 0;
    end
    m_cursor = 0;
  endtask

  task automatic model_key(input int key);
    bit ok;
    m_vv  = 0;
    m_err = 0;
    if (!m_active) return;
    if (key < 10) begin
      if (m_cursor < ND) begin
        m_buf[m_cursor] = key;
        m_cursor++;
      end
    end else if (key == 10) begin
      if (m_cursor > 0) begin
        m_cursor--;
        m_buf[m_cursor] = 0;
      end else begin
        m_buf = m_value;
      end
    end else begin
      ok = 1'b1;
      for (int p = 0; p < ND/2; p++) begin
        if (m_buf[2*p]*10 + m_buf[2*p+1] > lim[p]) ok = 1'b0;
      end
      if (ok) begin
        m_value = m_buf;
        m_vv    = 1;
      end else begin
        m_buf = m_value;
        m_err = 1;
      end
      m_cursor = 0;
    end
  endtask

  // Press one key cleanly; act 1 drops the mode and act 2 pulses rst at negedge act_k.
  task automatic press(input int key, input int act_k, input int act);
    vv_cnt  = 0;
    err_cnt = 0;
    vv_at   = -1;
    err_at  = -1;
    keypad_in = 12'b1 << key;
    for (int k = 1; k <= int'(HOLD + REL); k++) begin
      @(negedge clk);
      if (value_valid) begin
        vv_cnt++;
        if (vv_at < 0) vv_at = k;
      end
      if (error) begin
        err_cnt++;
        if (err_at < 0) err_at = k;
      end
      if (k == int'(HOLD)) keypad_in = '0;
      if (act == 1 && k == act_k) enable = 4'b0001;
      if (act == 2 && k == act_k) begin
        rst       = 1'b1;
        keypad_in = '0;
      end
      if (act == 2 && k == act_k + 1) begin
        snap_value  = value;
        snap_buf    = edit_buf;
        snap_cursor = cursor;
        snap_vv     = value_valid;
        snap_err    = error;
        snap_busy   = busy;
        rst         = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    enable    = 4'b0000;
    keypad_in = '0;
    m_active  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (value !== 24'h0 || edit_buf !== 24'h0) begin
      errors++; $display("FAIL reset_data got value %h buf %h want 000000", value, edit_buf);
    end
    checks++;
    if ({cursor, busy, value_valid, error} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got cursor %0d busy %b vv %b err %b want zeros", cursor, busy, value_valid, error);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_busy got %b want 0", busy);
    end
    enable = 4'b0100;
    @(negedge clk);
    m_active = 1'b1;
    checks++;
    if (busy !== 1'b1 || edit_buf !== exp_buf() || cursor !== 3'(m_cursor)) begin
      errors++; $display("FAIL enter_edit got busy %b buf %h cur %0d want 1 %h %0d", busy, edit_buf, cursor, exp_buf(), m_cursor);
    end
  endtask

  task automatic test_commit();
    for (int d = 1; d <= 6; d++) begin
      press(d, 0, 0);
      model_key(d);
      checks++;
      if (edit_buf !== exp_buf() || cursor !== 3'(m_cursor)) begin
        errors++; $display("FAIL commit_type got buf %h cur %0d want %h %0d", edit_buf, cursor, exp_buf(), m_cursor);
      end
    end
    press(11, 0, 0);
    model_key(11);
    checks++;
    if (value !== 24'h123456) begin
      errors++; $display("FAIL commit_value got %h want 123456", value);
    end
    checks++;
    if (vv_cnt !== 1 || vv_at !== int'(DB + 1) || err_cnt !== 0) begin
      errors++; $display("FAIL commit_pulse got vv %0d at %0d err %0d want 1 at %0d err 0", vv_cnt, vv_at, err_cnt, DB + 1);
    end
    checks++;
    if (cursor !== 3'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL commit_state got cur %0d busy %b want 0 1", cursor, busy);
    end
  endtask

  task automatic test_reject();
    int seq[6] = '{2, 5, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      press(seq[i], 0, 0);
      model_key(seq[i]);
    end
    checks++;
    if (edit_buf !== 24'h250000) begin
      errors++; $display("FAIL reject_typed got %h want 250000", edit_buf);
    end
    press(11, 0, 0);
    model_key(11);
    checks++;
    if (err_cnt !== 1 || err_at !== int'(DB + 1) || vv_cnt !== 0) begin
      errors++; $display("FAIL reject_pulse got err %0d at %0d vv %0d want 1 at %0d vv 0", err_cnt, err_at, vv_cnt, DB + 1);
    end
    checks++;
    if (value !== 24'h123456 || edit_buf !== 24'h123456 || cursor !== 3'd0) begin
      errors++; $display("FAIL reject_state got value %h buf %h cur %0d want 123456 123456 0", value, edit_buf, cursor);
    end
  endtask

  task automatic test_backspace();
    int seq[4] = '{1, 2, 10, 7};
    for (int i = 0; i < 4; i++) begin
      press(seq[i], 0, 0);
      model_key(seq[i]);
    end
    checks++;
    if (edit_buf !== 24'h173456 || cursor !== 3'd2) begin
      errors++; $display("FAIL bs_edit got buf %h cur %0d want 173456 2", edit_buf, cursor);
    end
    press(10, 0, 0);
    model_key(10);
    press(10, 0, 0);
    model_key(10);
    checks++;
    if (edit_buf !== 24'h003456 || cursor !== 3'd0 || edit_buf !== exp_buf()) begin
      errors++; $display("FAIL bs_clear got buf %h cur %0d want 003456 0", edit_buf, cursor);
    end
    press(10, 0, 0);
    model_key(10);
    checks++;
    if (edit_buf !== 24'h123456 || cursor !== 3'd0) begin
      errors++; $display("FAIL bs_cancel got buf %h cur %0d want 123456 0", edit_buf, cursor);
    end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 20; k++) begin
      keypad_in = ((k / 2) % 2 == 0) ? 12'h008 : 12'h000;
      @(negedge clk);
    end
    keypad_in = 12'h008;
    repeat (10) @(negedge clk);
    keypad_in = '0;
    repeat (REL) @(negedge clk);
    model_key(3);
    checks++;
    if (cursor !== 3'd1 || edit_buf !== exp_buf()) begin
      errors++; $display("FAIL bounce_one got buf %h cur %0d want %h 1", edit_buf, cursor, exp_buf());
    end
    keypad_in = 12'h028;
    repeat (10) @(negedge clk);
    keypad_in = '0;
    repeat (REL) @(negedge clk);
    checks++;
    if (cursor !== 3'd1 || edit_buf !== exp_buf()) begin
      errors++; $display("FAIL bounce_multi got buf %h cur %0d want %h 1", edit_buf, cursor, exp_buf());
    end
  endtask

  task automatic test_mode_exit();
    for (int pass = 0; pass < 2; pass++) begin
      press(pass == 0 ? 9 : 1, 0, 0);
      model_key(pass == 0 ? 9 : 1);
      press(11, int'(DB) - 1 + pass, 1);
      m_active = 1'b0;
      checks++;
      if (vv_cnt !== 0 || err_cnt !== 0 || busy !== 1'b0 || value !== exp_value()) begin
        errors++; $display("FAIL mode_exit%0d got vv %0d err %0d busy %b value %h want 0 0 0 %h", pass, vv_cnt, err_cnt, busy, value, exp_value());
      end
      enable = 4'b0100;
      repeat (2) @(negedge clk);
      m_active = 1'b1;
      m_buf    = m_value;
      m_cursor = 0;
      checks++;
      if (busy !== 1'b1 || edit_buf !== exp_buf() || cursor !== 3'd0) begin
        errors++; $display("FAIL mode_reenter%0d got busy %b buf %h cur %0d want 1 %h 0", pass, busy, edit_buf, cursor, exp_buf());
      end
    end
  endtask

  task automatic test_timeout();
    press(9, 0, 0);
    model_key(9);
    repeat (25) @(negedge clk);
    checks++;
    if (edit_buf !== exp_buf() || cursor !== 3'(m_cursor)) begin
      errors++; $display("FAIL timeout_early got buf %h cur %0d want %h %0d", edit_buf, cursor, exp_buf(), m_cursor);
    end
    repeat (25) @(negedge clk);
    m_buf    = m_value;
    m_cursor = 0;
    checks++;
    if (edit_buf !== exp_buf() || cursor !== 3'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_reload got buf %h cur %0d busy %b want %h 0 1", edit_buf, cursor, busy, exp_buf());
    end
  endtask

  task automatic test_random();
    int r, key;
    for (int n = 0; n < 40; n++) begin
      r   = int'($urandom_range(0, 99));
      key = (r < 70) ? int'($urandom_range(0, 9)) : (r < 85) ? 10 : 11;
      press(key, 0, 0);
      model_key(key);
      checks++;
      if (edit_buf !== exp_buf() || cursor !== 3'(m_cursor) || value !== exp_value()) begin
        errors++; $display("FAIL rand_state key %0d got buf %h cur %0d val %h want %h %0d %h", key, edit_buf, cursor, value, exp_buf(), m_cursor, exp_value());
      end
      checks++;
      if (vv_cnt !== m_vv || err_cnt !== m_err) begin
        errors++; $display("FAIL rand_pulse key %0d got vv %0d err %0d want %0d %0d", key, vv_cnt, err_cnt, m_vv, m_err);
      end
    end
  endtask

  task automatic test_reset_in_check();
    press(11, int'(DB), 2);
    model_reset();
    checks++;
    if (snap_value !== 24'h0 || snap_buf !== 24'h0 || snap_cursor !== 3'd0) begin
      errors++; $display("FAIL rst_check_data got value %h buf %h cur %0d want 000000 000000 0", snap_value, snap_buf, snap_cursor);
    end
    checks++;
    if ({snap_vv, snap_err, snap_busy} !== 3'b000 || vv_cnt !== 0 || err_cnt !== 0) begin
      errors++; $display("FAIL rst_check_ctrl got vv %b err %b busy %b pulses %0d/%0d want 0", snap_vv, snap_err, snap_busy, vv_cnt, err_cnt);
    end
    checks++;
    if (busy !== 1'b1 || edit_buf !== exp_buf() || value !== exp_value()) begin
      errors++; $display("FAIL rst_reenter got busy %b buf %h val %h want 1 %h %h", busy, edit_buf, value, exp_buf(), exp_value());
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_reject();
    test_backspace();
    test_bounce();
    test_mode_exit();
    test_timeout();
    test_random();
    test_reset_in_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_time_entry.md
# keypad_time_entry

Parametrised keypad entry block for the clock's set-time path: debounces a 12-key one-hot keypad, lets the user type an N-digit BCD value with backspace, cancel and commit, range-checks every digit pair, and only then updates the committed value. It sits between the keypad pins and the time-keeping counters, which load `value` on `value_valid`. Generalises the fixed 6-digit h/m/s entry path with configurable digit count, per-field limits, inactivity timeout and explicit error reporting.

## Interface
- `NUM_DIGITS`, 6: BCD digits; even, 2..8; digit pairs are fields, most significant first.
- `FIELD_MAX`, 24'h235959: packed BCD upper limit per pair, 8 bits per pair, width 4*NUM_DIGITS.
- `RESET_VALUE`, 0: `value` after reset, width 4*NUM_DIGITS.
- `ENTRY_MODE`, 4'b0100: `enable` code that activates entry.
- `DEBOUNCE_CYCLES`, 20000: stable cycles required for press and release, >= 2.
- `TIMEOUT_CYCLES`, 0: idle cycles in EDIT before the edit is discarded; 0 disables the timeout.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 4: mode select; entry is active iff `enable == ENTRY_MODE`.
- `keypad_in` in 12: active-high key levels; bit k for k=0..9 is digit k, bit 10 `*`, bit 11 `#`.
- `value` out 4*NUM_DIGITS: committed BCD value.
- `value_valid` out 1: one-cycle pulse when `value` is updated.
- `edit_buf` out 4*NUM_DIGITS: live edit contents for the display.
- `cursor` out $clog2(NUM_DIGITS+1): next digit position; 0 is the MSD.
- `busy` out 1: high in EDIT and CHECK.
- `error` out 1: one-cycle pulse when a commit is rejected.

## Operation
- Debounce. A press is accepted when exactly one bit is set and stays identical for DEBOUNCE_CYCLES consecutive cycles; this emits a single key event. The next press is not accepted until `keypad_in` has been all-zero for DEBOUNCE_CYCLES cycles. Any change in the pattern, or more than one bit set, restarts the count. Holding a key produces no repeat.
- FSM states are IDLE, EDIT and CHECK.
- IDLE -> EDIT when `enable == ENTRY_MODE`. On entry, `edit_buf` <= `value` and `cursor` <= 0.
- EDIT, digit d: write d at position `cursor`, then `cursor`+1. When `cursor == NUM_DIGITS`, digits are ignored.
- EDIT, `*` with cursor>0: `cursor`-1 and that digit is cleared to 0.
- EDIT, `*` with cursor==0: cancel. Reload `edit_buf` from `value`.
- EDIT, `#`: go to CHECK.
- CHECK, one cycle: every pair of `edit_buf` is compared with its FIELD_MAX pair as an unsigned 8-bit BCD compare.
  - All pairs within limit: `value` <= `edit_buf` and pulse `value_valid`.
  - Any pair over limit: pulse `error`, reload `edit_buf` from `value`.
  - In both cases `cursor` <= 0 and the FSM returns to EDIT.
- Commit is allowed at any cursor position. Untyped digits keep their loaded values.
- `enable != ENTRY_MODE` in EDIT or CHECK: go to IDLE and discard the edit. `value` is unchanged and no pulse is issued. Leaving the mode wins over a `#` event or CHECK in the same cycle.
- Timeout: after TIMEOUT_CYCLES cycles in EDIT with no key event, reload `edit_buf` from `value`, set `cursor` <= 0 and stay in EDIT. Any key event restarts the counter.
- The debouncer runs in every state. Events that occur in IDLE are dropped.

## Timing
- Reset values: `value`=RESET_VALUE, `edit_buf`=RESET_VALUE, `cursor`=0, `value_valid`=0, `error`=0, `busy`=0, state IDLE, debounce and timeout counters 0.
- Key event: asserted in the cycle the stable count reaches DEBOUNCE_CYCLES, which is cycle DEBOUNCE_CYCLES-1 after the pattern first appears. `edit_buf` and `cursor` update on the next edge.
- `#` event at cycle t: CHECK during t+1. `value`, `value_valid` or `error` are visible in t+2, and the FSM is back in EDIT at t+2.
- Entering the mode at cycle t: EDIT, `busy`=1 and the loaded `edit_buf` are visible at t+1.
- All outputs are registered.
- `rst` overrides everything in the same edge, including mid-debounce and CHECK.

## Structure
- `keypad_pkg`:
  - key index constants `KEY_STAR`=10 and `KEY_HASH`=11;
  - FSM state enum;
  - default ENTRY_MODE.
- Sub-module `keypad_debounce`: `keypad_in` -> {`key_evt`, `key_code[3:0]`}, parametrised by DEBOUNCE_CYCLES.
- Top `keypad_time_entry` holds the FSM, edit buffer, cursor, range check and timeout counter.

## Test plan
DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=50 throughout.
- Reset, `enable`=4'b0100, type 1,2,3,4,5,6 then `#` -> `value`=24'h123456, `value_valid` pulses once, 2 cycles after the `#` event.
- Type 2,5,0,0,0,0 then `#` -> `error` pulses once, `value` unchanged, `edit_buf`=`value`, `cursor`=0.
- Type 1,2,`*`,7 -> `edit_buf` begins 1,7,… and `cursor`=2. Then `*`,`*`,`*` with cursor reaching 0 -> the third `*` reloads `edit_buf` from `value`.
- Bounce: `keypad_in` toggles bit 3 every 2 cycles for 20 cycles, then holds 10 cycles -> exactly one event, digit 3. Bits 3 and 5 held together -> no event.
- Mid-edit, `enable` set to 4'b0001 at the same cycle as the `#` event -> IDLE, no `value_valid`, `value` unchanged.
- In EDIT, no keys for 50 cycles -> `edit_buf` reloaded and `cursor`=0. `rst` asserted during CHECK -> all outputs at their reset values on the next cycle.
